// File: rtl/uart_fifo.sv
// uart_fifo - parametrised single-clock FIFO for UART byte streams and other
// single-clock word streams.
//
// Parameters:
//   DATA_W   word width
//   ADDR_W   log2 of memory depth (DEPTH = 2**ADDR_W)
//   AF_LEVEL almost_full threshold on level (1..DEPTH)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous clear of contents (error flags kept)
//   err_clr           clears overflow/underflow
//   wrdata, wr_en     write side
//   rddata, rd_en     registered read word, pop request
//   empty, full       status
//   almost_full       level >= AF_LEVEL
//   level             words held
//   overflow          sticky: write attempted while full
//   underflow         sticky: pop attempted while empty
//
// Build option: define UART_FIFO_FWFT_EN for first-word-fall-through reads.
// In that mode an output register with its own valid bit sits after the
// memory, so total capacity is DEPTH+1 and rddata is the head word whenever
// empty is low. Without it, rddata is a plain registered read of mem[rdidx].
module uart_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 9,
  parameter int AF_LEVEL = 384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rddata,
  input  logic              rd_en,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_THR    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wridx, rdidx;
  logic [ADDR_W:0]   count, count_nxt;
  logic              wr_acc, wr_rej, rd_acc, rd_rej;
  logic              mem_rd;   // a word leaves the memory this cycle

`ifdef UART_FIFO_FWFT_EN
  logic valid;               // output register holds the head word
`endif

  // Flush suppresses both requests entirely, including their error side effects.
  always_comb begin
    wr_acc = wr_en && !full  && !flush;
    wr_rej = wr_en &&  full  && !flush;
    rd_acc = rd_en && !empty && !flush;
    rd_rej = rd_en &&  empty && !flush;
`ifdef UART_FIFO_FWFT_EN
    // Refill the output register when it is free or being drained.
    mem_rd = (!valid || rd_acc) && (count != '0) && !flush;
`else
    mem_rd = rd_acc;
`endif
  end

  always_comb begin
    count_nxt = count;
    case ({wr_acc, mem_rd})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage: no reset, written only on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wridx] <= wrdata;
  end

  // Read register. Holds its value across a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rddata <= '0;
`ifdef UART_FIFO_FWFT_EN
    end else if (mem_rd) begin
`else
    end else if (!flush) begin
`endif
      rddata <= mem[rdidx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wridx     <= '0;
      rdidx     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef UART_FIFO_FWFT_EN
      valid     <= 1'b0;
`endif
    end else begin
      if (flush) begin
        wridx <= '0;
        rdidx <= '0;
        count <= '0;
`ifdef UART_FIFO_FWFT_EN
        valid <= 1'b0;
`endif
      end else begin
        if (wr_acc) wridx <= wridx + IDX_ONE;
        if (mem_rd) rdidx <= rdidx + IDX_ONE;
        count <= count_nxt;
`ifdef UART_FIFO_FWFT_EN
        if (mem_rd)      valid <= 1'b1;
        else if (rd_acc) valid <= 1'b0;
`endif
      end
      // A new error in the same cycle as err_clr wins.
      overflow  <= (overflow  && !err_clr) || wr_rej;
      underflow <= (underflow && !err_clr) || rd_rej;
    end
  end

  always_comb begin
`ifdef UART_FIFO_FWFT_EN
    empty = !valid;
    level = count + {{ADDR_W{1'b0}}, valid};
`else
    empty = (count == '0);
    level = count;
`endif
    full        = (count == DEPTH_CNT);
    almost_full = (level >= AF_THR);
  end

endmodule
